dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU port) and the AES coprocessor's load/store engine (AES port).
- The CPU owns the port by default. The AES engine is granted bounded bursts when the CPU is idle, or when its wait counter expires.
- While the AES engine owns the port, the block stalls the CPU MEM stage.
- Sits between the EX_MEM outputs / MEM_WB inputs and the data memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_WAIT, 8, AES request cycles blocked by CPU traffic before a forced handover (1..255).
- BURST_MAX, 4, maximum AES beats per grant (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cpu_re  in  1  CPU MEM-stage read
- cpu_we  in  1  CPU MEM-stage write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data (combinational from memory)
- cpu_stall  out  1  freeze MEM stage and upstream
- aes_req  in  1  AES beat request
- aes_we  in  1  AES beat is a write
- aes_last  in  1  final beat of AES burst
- aes_addr  in  ADDR_W  AES address
- aes_wdata  in  DATA_W  AES write data
- aes_gnt  out  1  AES owns the port this cycle
- aes_rdata  out  DATA_W  registered AES read data
- aes_rvalid  out  1  aes_rdata valid
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational read)
- perf_stall_cnt  out  32  CPU stall-cycle count (optional feature)
- perf_aes_beats  out  32  accepted AES beat count (optional feature)

Behaviour:
- Memory model: combinational read, write on rising clk edge when mem_we=1.
- Reset (rst=0, asynchronous) sets:
  - state=CPU_OWN, wait_cnt=0, beat_cnt=0
  - aes_gnt=0, aes_rvalid=0, aes_rdata=0, perf counters=0
- All other outputs are combinational from state and inputs.
- cpu_act = cpu_re|cpu_we. A beat is accepted when aes_req & aes_gnt.

CPU_OWN state:
- The memory mux selects the CPU port.
- aes_gnt=0, cpu_stall=0.
- wait_cnt increments each cycle with aes_req & cpu_act, saturating at MAX_WAIT. It clears when aes_req=0.
- Transition to AES_BURST at the next edge if aes_req & (!cpu_act | wait_cnt==MAX_WAIT).
- Grant latency is exactly one cycle from the qualifying cycle.
- On the transition, clear wait_cnt and beat_cnt.

AES_BURST state:
- The memory mux selects the AES port.
- aes_gnt=1. mem_re = aes_req & !aes_we; mem_we = aes_req & aes_we.
- cpu_stall = cpu_act. The CPU holds its request stable while stalled.
- Each accepted beat increments beat_cnt.
- Return to CPU_OWN at the next edge on any of:
  - accepted beat with aes_last=1;
  - accepted beat with beat_cnt==BURST_MAX-1;
  - aes_req=0 (burst abandoned, no beat).
- Ownership cannot return to AES without a new qualifying request evaluated in CPU_OWN.

AES read data:
- An accepted read beat registers mem_rdata into aes_rdata.
- aes_rvalid=1 on the following cycle only, one pulse per read beat.
- aes_rdata holds its value otherwise.

Write and reset rules:
- Writes never see stale data; a CPU read after an AES write observes the new value.
- No memory enable is ever asserted for the non-owning port.
- Reset mid-burst: ownership returns to the CPU immediately. The in-flight aes_rvalid is dropped.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle cpu_stall=1.
  - perf_aes_beats increments on every accepted AES beat.
  - Both are 32-bit wrapping counters, cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then CPU read of addr 0x10 holding 0xCAFE0001 with aes_req=0 -> cpu_rdata=0xCAFE0001, cpu_stall=0, aes_gnt=0 throughout.
- CPU idle; AES requests a 3-beat write to 0x100/0x104/0x108 with aes_last on beat 3 ->
  - aes_gnt rises 1 cycle after aes_req.
  - Memory holds the 3 words.
  - State returns to CPU_OWN after beat 3.
- CPU issues back-to-back accesses every cycle while aes_req=1 -> forced handover after 8 blocked cycles (MAX_WAIT=8); cpu_stall=1 during the burst.
- AES 6-beat read burst without aes_last, BURST_MAX=4 ->
  - Grant drops after 4 beats, with aes_rvalid pulses on 4 consecutive cycles.
  - Re-grant occurs for the remaining beats.
- aes_req deasserted mid-burst after beat 2 -> aes_gnt=0 next cycle; a CPU write to 0x20 proceeds unstalled.
- rst asserted during an AES burst -> aes_gnt=0, aes_rvalid=0 immediately. With DMEM_ARB_PERF_EN: perf_aes_beats counts accepted beats, and both perf counters clear on the asserted reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
//   Shares the single data-memory port between the CPU MEM stage and the
//   AES coprocessor load/store engine. The CPU owns the port by default. The
//   AES engine gets a bounded burst when the CPU is idle, or once its request
//   has been blocked for MAX_WAIT cycles. While AES owns the port, any CPU
//   access is stalled.
//
//   Optional build macro: DMEM_ARB_PERF_EN enables 32-bit wrapping
//   performance counters. Without it, the perf ports are tied to zero.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   cpu_re/we/addr/wdata       CPU MEM-stage request
//   cpu_rdata, cpu_stall       CPU read data (combinational), MEM-stage freeze
//   aes_req/we/last/addr/wdata AES beat request
//   aes_gnt                    AES owns the port this cycle
//   aes_rdata, aes_rvalid      registered AES read data and its one-cycle strobe
//   mem_re/we/addr/wdata/rdata data-memory port
//   perf_stall_cnt             CPU stall-cycle count
//   perf_aes_beats             accepted AES beat count
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aes_req,
  input  logic              aes_we,
  input  logic              aes_last,
  input  logic [ADDR_W-1:0] aes_addr,
  input  logic [DATA_W-1:0] aes_wdata,
  output logic              aes_gnt,
  output logic [DATA_W-1:0] aes_rdata,
  output logic              aes_rvalid,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_aes_beats
);

  typedef enum logic {
    CPU_OWN   = 1'b0,
    AES_BURST = 1'b1
  } state_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [4:0] BEAT_FINAL = 5'(BURST_MAX - 1);

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d;
  logic              aes_rvalid_q, aes_rvalid_d;
  logic [DATA_W-1:0] aes_rdata_q, aes_rdata_d;

  logic cpu_act;
  logic aes_own;
  logic beat_acc;

  assign cpu_act  = cpu_re | cpu_we;
  assign aes_own  = (state_q == AES_BURST);
  assign beat_acc = aes_req & aes_own;

  // Ownership is the state register itself, so the grant is a flop output.
  assign aes_gnt    = aes_own;
  assign cpu_stall  = aes_own & cpu_act;
  assign cpu_rdata  = mem_rdata;
  assign aes_rdata  = aes_rdata_q;
  assign aes_rvalid = aes_rvalid_q;

  // Port mux: the non-owning side never reaches the memory enables.
  always_comb begin
    if (aes_own) begin
      mem_re    = aes_req & ~aes_we;
      mem_we    = aes_req & aes_we;
      mem_addr  = aes_addr;
      mem_wdata = aes_wdata;
    end else begin
      mem_re    = cpu_re;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (aes_req) begin
          if (!cpu_act || wait_cnt_q == WAIT_LIMIT) begin
            state_d    = AES_BURST;
            wait_cnt_d = '0;
            beat_cnt_d = '0;
          end else begin
            // Blocked by CPU traffic; below the limit here, so no overflow.
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      AES_BURST: begin
        if (!aes_req) begin
          state_d = CPU_OWN;
        end else begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (aes_last || beat_cnt_q == BEAT_FINAL) begin
            state_d = CPU_OWN;
          end
        end
      end
    endcase
  end

  always_comb begin
    aes_rvalid_d = beat_acc & ~aes_we;
    aes_rdata_d  = aes_rvalid_d ? mem_rdata : aes_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CPU_OWN;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      aes_rvalid_q <= 1'b0;
      aes_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      aes_rvalid_q <= aes_rvalid_d;
      aes_rdata_q  <= aes_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_aes_beats_q, perf_aes_beats_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(cpu_stall);
    perf_aes_beats_d = perf_aes_beats_q + 32'(beat_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt_q <= '0;
      perf_aes_beats_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_aes_beats_q <= perf_aes_beats_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_aes_beats = perf_aes_beats_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_aes_beats = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Testbench for dmem_arbiter: randomized and directed traffic, checked against
// a transaction-level ownership model and a reference copy of memory.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re, cpu_we, aes_req, aes_we, aes_last;
  logic [31:0] cpu_addr, cpu_wdata, aes_addr, aes_wdata;
  logic [31:0] cpu_rdata, aes_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] perf_stall_cnt, perf_aes_beats;
  logic        cpu_stall, aes_gnt, aes_rvalid, mem_re, mem_we;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aes_req(aes_req), .aes_we(aes_we), .aes_last(aes_last), .aes_addr(aes_addr),
    .aes_wdata(aes_wdata), .aes_gnt(aes_gnt), .aes_rdata(aes_rdata), .aes_rvalid(aes_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_stall_cnt(perf_stall_cnt), .perf_aes_beats(perf_aes_beats)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hCAFE_0001;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory attached to the DUT: combinational read, write on rising edge.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  logic [31:0] aes_q[$];
  logic [31:0] cpu_q[$];
  bit m_own, m_prev_stall;
  int m_wait, m_burst, m_stall_cnt, m_beat_cnt;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares data whenever the DUT presents it.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (aes_rvalid) begin
        if (aes_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL aes_rvalid_unexpected: got 1 expected 0 at %0t", $time);
        end else chk("aes_rdata", aes_rdata, aes_q.pop_front());
      end
      if (cpu_re && !cpu_stall && !aes_gnt) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_read_unexpected: got read expected none at %0t", $time);
        end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
    end
  end

  // One clock cycle: inputs are already set; predict, check, advance the model.
  task automatic step(output bit acc);
    bit act, e_re, e_we;
    logic [31:0] e_addr, e_wdata;
    act = cpu_re | cpu_we;
    acc = aes_req & m_own;
    if (m_own) begin
      e_re = aes_req & ~aes_we; e_we = aes_req & aes_we; e_addr = aes_addr; e_wdata = aes_wdata;
    end else begin
      e_re = cpu_re; e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end
    if (acc && !aes_we) aes_q.push_back(ref_mem[aes_addr[11:2]]);
    if (!m_own && cpu_re) cpu_q.push_back(ref_mem[cpu_addr[11:2]]);
    @(negedge clk);
    chk("aes_gnt", 32'(aes_gnt), 32'(m_own));
    chk("cpu_stall", 32'(cpu_stall), 32'(m_own & act));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    if (e_we) ref_mem[e_addr[11:2]] = e_wdata;
    m_prev_stall = m_own & act;
    if (m_own && act) m_stall_cnt++;
    if (acc) m_beat_cnt++;
    if (!m_own) begin
      if (aes_req && (!act || m_wait == MAX_WAIT)) begin
        m_own = 1; m_wait = 0; m_burst = 0;
      end else if (aes_req) begin
        m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      end else m_wait = 0;
    end else if (acc) begin
      m_burst++;
      if (aes_last || m_burst == BURST_MAX) m_own = 0;
    end else m_own = 0;
    @(posedge clk); #1;
  endtask

  // A stalled CPU keeps its request unchanged.
  task automatic cpu_next(input bit busy);
    if (m_prev_stall) return;
    if (busy) begin
      if ($urandom_range(0, 1) == 1) begin cpu_re = 1; cpu_we = 0; end
      else begin cpu_re = 0; cpu_we = 1; end
      cpu_addr  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cpu_wdata = $urandom;
    end else begin
      cpu_re = 0; cpu_we = 0;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    aes_req = 0; aes_last = 0; aes_we = 0;
    for (int k = 0; k < n; k++) begin
      cpu_next(1'b0);
      step(acc);
    end
  endtask

  task automatic aes_burst(input int n, input bit we, input bit use_last,
                           input logic [31:0] base, input logic [31:0] dbase, input bit busy);
    int i;
    int budget;
    bit acc;
    i = 0;
    budget = 100;
    while (i < n && budget > 0) begin
      aes_req = 1; aes_we = we;
      aes_addr  = base + 32'(4 * i);
      aes_wdata = dbase + 32'(i);
      aes_last  = use_last && (i == n - 1);
      cpu_next(busy);
      step(acc);
      if (acc) i++;
      budget--;
    end
    chk("burst_beats_done", 32'(i), 32'(n));
    aes_req = 0; aes_last = 0; aes_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aes_req = 0; aes_we = 0; aes_last = 0; aes_addr = '0; aes_wdata = '0;
    m_own = 0; m_prev_stall = 0; m_wait = 0; m_burst = 0; m_stall_cnt = 0; m_beat_cnt = 0;

    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aes_gnt", 32'(aes_gnt), 32'd0);
    chk("rst_aes_rvalid", 32'(aes_rvalid), 32'd0);
    chk("rst_aes_rdata", aes_rdata, 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_beats", perf_aes_beats, 32'd0);
    rst = 1;

    // CPU read of 0x10 with no AES traffic
    cpu_re = 1; cpu_addr = 32'h10;
    step(acc);
    chk("cpu_rd_0x10", cpu_rdata, 32'hCAFE_0001);
    step(acc);
    idle(1);

    // 3-beat AES write with aes_last on the final beat, CPU idle
    aes_burst(3, 1'b1, 1'b1, 32'h100, 32'hA5A5_0000, 1'b0);
    idle(2);
    for (int k = 0; k < 3; k++) chk("aes_wr_mem", mem[64 + k], 32'hA5A5_0000 + 32'(k));

    // Forced handover under continuous CPU traffic
    aes_burst(2, 1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 1'b1);
    idle(3);

    // 6-beat read burst with no aes_last: split at BURST_MAX
    aes_burst(6, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
    idle(3);

    // Burst abandoned after 2 beats, then an unstalled CPU write/read of 0x20
    aes_burst(2, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0);
    cpu_re = 0; cpu_we = 0;
    step(acc);
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    step(acc);
    cpu_we = 0; cpu_re = 1;
    step(acc);
    chk("cpu_wr_0x20_mem", mem[8], 32'h1234_5678);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      aes_req   = ($urandom_range(0, 3) != 0);
      aes_we    = ($urandom_range(0, 1) == 1);
      aes_last  = ($urandom_range(0, 3) == 0);
      aes_addr  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      aes_wdata = $urandom;
      cpu_next($urandom_range(0, 2) != 0);
      step(acc);
    end
    idle(6);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall_cnt));
    chk("perf_aes_beats", perf_aes_beats, 32'(m_beat_cnt));
`else
    chk("perf_stall_tied", perf_stall_cnt, 32'd0);
    chk("perf_beats_tied", perf_aes_beats, 32'd0);
`endif

    // Reset asserted mid-burst with a read strobe in flight
    cpu_re = 0; cpu_we = 0;
    aes_req = 1; aes_we = 0; aes_last = 0; aes_addr = 32'h100;
    step(acc);
    step(acc);
    chk("pre_rst_aes_rvalid", 32'(aes_rvalid), 32'd1);
`ifdef DMEM_ARB_PERF_EN
    chk("pre_rst_perf_beats", perf_aes_beats, 32'(m_beat_cnt));
`endif
    #2 rst = 0;
    #1;
    chk("mid_rst_aes_gnt", 32'(aes_gnt), 32'd0);
    chk("mid_rst_aes_rvalid", 32'(aes_rvalid), 32'd0);
    chk("mid_rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("mid_rst_perf_beats", perf_aes_beats, 32'd0);
    aes_q.delete();
    m_own = 0; m_prev_stall = 0; m_wait = 0; m_burst = 0; m_stall_cnt = 0; m_beat_cnt = 0;
    aes_req = 0;
    @(posedge clk); #1;
    rst = 1;
    idle(2);
    cpu_re = 1; cpu_addr = 32'h104;
    step(acc);
    idle(2);

    chk("aes_q_drained", 32'(aes_q.size()), 32'd0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
